umult_share_arb: RTL and testbench

//   Shares one combinational WIDTH-bit unsigned multiplier between two requesters.

---
 rtl/umult_share_arb.sv | 155 +++++++++++++++
 tb/tb_umult_share_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/umult_share_arb.sv
// umult_share_arb
//   Shares one external combinational unsigned multiplier between two requesters.
//   A round-robin arbiter accepts one operation in IDLE and registers its operands
//   onto the multiplier inputs. The product is registered one cycle later, then
//   held on a valid/ready response port until the consumer takes it.
//   Best-case throughput is one multiply every 3 cycles.
//
// Ports
//   clk                      clock, all state updates on posedge
//   rst_n                    synchronous active-low reset
//   req0_valid/_a/_b         requester 0 operation
//   req0_ready               requester 0 accepted this cycle (combinational)
//   req1_valid/_a/_b         requester 1 operation
//   req1_ready               requester 1 accepted this cycle (combinational)
//   mul_a, mul_b             registered operands to the shared multiplier
//   mul_p                    combinational product from the shared multiplier
//   rsp_valid/_id/_p         registered result, owner id and product
//   rsp_ready                consumer accepts the result

module umult_share_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_p,
  input  logic               rsp_ready
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

  // State registers
  state_e               r_state;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;
  logic                 r_rsp_valid;
  logic                 r_rsp_id;
  logic [2*WIDTH-1:0]   r_rsp_p;
  logic                 r_last_grant;

  // Next-state values
  state_e               w_state_next;
  logic [WIDTH-1:0]     w_mul_a_next;
  logic [WIDTH-1:0]     w_mul_b_next;
  logic                 w_rsp_valid_next;
  logic                 w_rsp_id_next;
  logic [2*WIDTH-1:0]   w_rsp_p_next;
  logic                 w_last_grant_next;

  // Arbitration
  logic                 w_any_valid;
  logic                 w_grant;
  logic                 w_accept;

  // With both requesting, favour the one not served last; otherwise the single
  // valid requester wins (req1_valid alone selects 1, req0_valid alone selects 0).
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
    // Reset masks the handshake so a requester never sees an accept that is
    // about to be discarded.
    w_accept = rst_n && (r_state == StIdle) && w_any_valid;
  end

  always_comb begin
    req0_ready = w_accept && (w_grant == 1'b0);
    req1_ready = w_accept && (w_grant == 1'b1);
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_next      = r_state;
    w_mul_a_next      = r_mul_a;
    w_mul_b_next      = r_mul_b;
    w_rsp_valid_next  = r_rsp_valid;
    w_rsp_id_next     = r_rsp_id;
    w_rsp_p_next      = r_rsp_p;
    w_last_grant_next = r_last_grant;

    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_mul_a_next      = w_grant ? req1_a : req0_a;
          w_mul_b_next      = w_grant ? req1_b : req0_b;
          w_rsp_id_next     = w_grant;
          w_last_grant_next = w_grant;
          w_state_next      = StCalc;
        end
      end
      StCalc: begin
        // Operands have been stable at the multiplier for a full cycle.
        w_rsp_p_next     = mul_p;
        w_rsp_valid_next = 1'b1;
        w_state_next     = StResp;
      end
      StResp: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_next = 1'b0;
          w_state_next     = StIdle;
        end
      end
      default: begin
        w_state_next     = StIdle;
        w_rsp_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_p      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_mul_a      <= w_mul_a_next;
      r_mul_b      <= w_mul_b_next;
      r_rsp_valid  <= w_rsp_valid_next;
      r_rsp_id     <= w_rsp_id_next;
      r_rsp_p      <= w_rsp_p_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_p     = r_rsp_p;

endmodule

// File: tb/tb_umult_share_arb.sv
module tb_umult_share_arb;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           req0_valid;
  logic [W-1:0]   req0_a;
  logic [W-1:0]   req0_b;
  logic           req0_ready;
  logic           req1_valid;
  logic [W-1:0]   req1_a;
  logic [W-1:0]   req1_b;
  logic           req1_ready;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_p;
  logic           rsp_valid;
  logic           rsp_id;
  logic [2*W-1:0] rsp_p;
  logic           rsp_ready;

  int n_checks;
  int n_pass;

  umult_share_arb #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p),
    .rsp_ready  (rsp_ready)
  );

  // Stand-in for the shared combinational multiplier
  assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after the edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6;
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %0d want 0", rsp_valid);
      else n_pass++;
      n_checks++;
      if (rsp_p !== 8'd0) $display("FAIL reset_rsp_p: got %0d want 0", rsp_p);
      else n_pass++;
      n_checks++;
      if (mul_a !== 4'd0 || mul_b !== 4'd0)
        $display("FAIL reset_mul: got a=%0d b=%0d want 0 0", mul_a, mul_b);
      else n_pass++;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL reset_ready: got r0=%0d r1=%0d want 0 0", req0_ready, req1_ready);
      else n_pass++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 4'd15; req0_b = 4'd15; rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL single_accept: got r0=%0d r1=%0d want 1 0", req0_ready, req1_ready);
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b0 || rsp_valid !== 1'b0 || mul_a !== 4'd15 || mul_b !== 4'd15)
      $display("FAIL single_calc: got r0=%0d v=%0d a=%0d b=%0d want 0 0 15 15",
               req0_ready, rsp_valid, mul_a, mul_b);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 8'd225 || rsp_id !== 1'b0)
      $display("FAIL single_rsp: got v=%0d p=%0d id=%0d want 1 225 0",
               rsp_valid, rsp_p, rsp_id);
    else n_pass++;
    rsp_ready = 1'b1;
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_done: got v=%0d want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_p;
    // Fresh reset so the first contested grant goes to requester 0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
    req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd9;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = k[0];
      exp_p  = exp_id ? 8'd63 : 8'd15;
      #1;
      n_checks++;
      if (req0_ready !== ~exp_id || req1_ready !== exp_id)
        $display("FAIL rr_grant%0d: got r0=%0d r1=%0d want id %0d",
                 k, req0_ready, req1_ready, exp_id);
      else n_pass++;
      tick(); #1;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL rr_calc_ready%0d: got r0=%0d r1=%0d want 0 0", k, req0_ready, req1_ready);
      else n_pass++;
      tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== exp_p || rsp_id !== exp_id)
        $display("FAIL rr_rsp%0d: got v=%0d p=%0d id=%0d want 1 %0d %0d",
                 k, rsp_valid, rsp_p, rsp_id, exp_p, exp_id);
      else n_pass++;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_stall();
    // last grant is 1 here, so requester 0 wins the contest
    req0_valid = 1'b1; req0_a = 4'd4; req0_b = 4'd11;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd3;
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) $display("FAIL stall_grant0: got r0=%0d want 1", req0_ready);
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== 8'd44 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got v=%0d p=%0d id=%0d r0=%0d r1=%0d want 1 44 0 0 0",
                 c, rsp_valid, rsp_p, rsp_id, req0_ready, req1_ready);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    tick(); #1;
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL stall_resume: got r0=%0d r1=%0d v=%0d want 0 1 0",
               req0_ready, req1_ready, rsp_valid);
    else n_pass++;
    tick();
    req1_valid = 1'b0;
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 8'd6 || rsp_id !== 1'b1)
      $display("FAIL stall_next_rsp: got v=%0d p=%0d id=%0d want 1 6 1", rsp_valid, rsp_p, rsp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_in_calc();
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9; rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) $display("FAIL abort_accept: got r0=%0d want 1", req0_ready);
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || mul_a !== 4'd0)
        $display("FAIL abort_no_rsp%0d: got v=%0d a=%0d want 0 0", c, rsp_valid, mul_a);
      else n_pass++;
      tick();
    end
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd6;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) $display("FAIL abort_next_accept: got r0=%0d want 1", req0_ready);
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    tick(); #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 8'd12 || rsp_id !== 1'b0)
      $display("FAIL abort_next_rsp: got v=%0d p=%0d id=%0d want 1 12 0", rsp_valid, rsp_p, rsp_id);
    else n_pass++;
    tick();
  endtask

  task automatic test_sweep();
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_p;
      exp_p = 8'(i * i);
      req1_valid = 1'b1; req1_a = 4'(i); req1_b = 4'(i);
      #1;
      n_checks++;
      if (req1_ready !== 1'b1) $display("FAIL sweep_accept%0d: got r1=%0d want 1", i, req1_ready);
      else n_pass++;
      tick();
      req1_valid = 1'b0;
      tick(); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== exp_p || rsp_id !== 1'b1)
        $display("FAIL sweep_rsp%0d: got v=%0d p=%0d id=%0d want 1 %0d 1",
                 i, rsp_valid, rsp_p, rsp_id, exp_p);
      else n_pass++;
      tick();
    end
    // Operands persist at the multiplier after completion
    tick(); #1;
    n_checks++;
    if (mul_a !== 4'd15 || mul_b !== 4'd15 || rsp_valid !== 1'b0)
      $display("FAIL mul_hold: got a=%0d b=%0d v=%0d want 15 15 0", mul_a, mul_b, rsp_valid);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_in_calc();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
